uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_pkg.sv | 36 +++
 rtl/uart_parity_calc.sv | 21 ++
 rtl/uart_tx_framer.sv | 148 ++++++++++++++
 tb/tb_uart_tx_framer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit framer: state encoding,
// parity-type constants, legal data-width limits and the per-frame
// configuration captured at accept.
package uart_tx_pkg;

  // Frame sequencer states, in transmission order.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP_1 = 3'd4,
    STOP_2 = 3'd5
  } tx_state_t;

  // PAR_TYP encodings.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Supported data bits per frame.
  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;

  // Serial line levels.
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  // Frame options captured together with the data word at accept.
  typedef struct packed {
    logic par_en;
    logic par_typ;
    logic stop2;
  } frame_cfg_t;

endpackage

// File: rtl/uart_parity_calc.sv
// Purpose : parity bit for a UART frame (even = XOR of data, odd = inverted XOR).
// Latency : combinational, no clock.
// Flow    : none; output follows inputs.
// Ports   : data    - latched data word
//           par_typ - PAR_EVEN / PAR_ODD
//           parity  - parity bit to place on the line
module uart_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  // Odd parity makes the total count of ones (data + parity) odd,
  // which is the even result inverted.
  assign parity = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_framer.sv
// Purpose : serialises one parallel word into a UART frame
//           (start, DATA_WIDTH bits LSB first, optional parity, 1 or 2 stops).
// Latency : accept edge drives the start bit (1 cycle); each later bit
//           advances on a TICK-qualified edge.
// Flow    : requests are taken only in IDLE or on the frame-end edge;
//           DATA_VALID at any other time while BUSY is dropped, not queued.
// Ports   : CLK, RST (async, active-low), TICK (baud enable),
//           P_DATA / DATA_VALID (word + request), PAR_EN / PAR_TYP / STOP2
//           (frame options), TX_OUT (registered line), BUSY, DONE (1-cycle).
module uart_tx_framer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TICK,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  DONE
);

  generate
    if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_width
      $error("uart_tx_framer: DATA_WIDTH must be within 5..9");
    end
  endgenerate

  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_t             state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      next_cnt;
  logic [DATA_WIDTH-1:0] data_q;
  frame_cfg_t            cfg_q;
  logic                  parity_bit;
  logic                  tx_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  frame_end;
  logic                  accept;

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

  // Parity works on the latched word so mid-frame input changes cannot leak in.
  uart_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data    (data_q),
    .par_typ (cfg_q.par_typ),
    .parity  (parity_bit)
  );

  assign next_cnt = bit_cnt + CNT_W'(1);

  // The tick that leaves the final stop state closes the frame.
  assign frame_end = TICK && ((state == STOP_1 && !cfg_q.stop2) || (state == STOP_2));

  // A request is taken from IDLE, or on the frame-end edge for back-to-back
  // frames with no idle bit in between.
  assign accept = DATA_VALID && ((state == IDLE) || frame_end);

  // Sequencer with registered line, busy and done. TX_OUT is loaded with the
  // level belonging to the state being entered, so line and state move on the
  // same edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      bit_cnt <= '0;
      data_q  <= '0;
      cfg_q   <= '0;
      tx_q    <= LINE_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (accept) begin
        // A coincident TICK is deliberately ignored here so START lasts a
        // full bit period from this edge.
        data_q  <= P_DATA;
        cfg_q   <= '{par_en: PAR_EN, par_typ: PAR_TYP, stop2: STOP2};
        bit_cnt <= '0;
        state   <= START;
        tx_q    <= LINE_START;
        busy_q  <= 1'b1;
        done_q  <= frame_end;
      end else if (frame_end) begin
        state  <= IDLE;
        tx_q   <= LINE_IDLE;
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end else if (TICK) begin
        case (state)
          IDLE: begin
            // Baud ticks have no effect while idle.
          end
          START: begin
            state   <= DATA;
            bit_cnt <= '0;
            tx_q    <= data_q[0];
          end
          DATA: begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (cfg_q.par_en) begin
                state <= PARITY;
                tx_q  <= parity_bit;
              end else begin
                state <= STOP_1;
                tx_q  <= LINE_STOP;
              end
            end else begin
              bit_cnt <= next_cnt;
              tx_q    <= data_q[next_cnt];
            end
          end
          PARITY: begin
            state <= STOP_1;
            tx_q  <= LINE_STOP;
          end
          STOP_1: begin
            // Only reached with two stop bits; one stop bit ends via frame_end.
            state <= STOP_2;
            tx_q  <= LINE_STOP;
          end
          STOP_2: begin
            // Leaving STOP_2 is always a frame end, handled above.
          end
          default: begin
            state  <= IDLE;
            tx_q   <= LINE_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: one 8-bit and one 5-bit instance share the line
// options; a queue holds the expected line level for every bit period and is
// popped as ticks advance the frame.
module tb_uart_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [7:0] p_data8;
  logic [4:0] p_data5;
  logic       dv8, dv5;
  logic       par_en, par_typ, stop2;
  logic       tx8, busy8, done8;
  logic       tx5, busy5, done5;

  always #5 clk = ~clk;

  uart_tx_framer #(.DATA_WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst_n), .TICK(tick), .P_DATA(p_data8), .DATA_VALID(dv8),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
    .TX_OUT(tx8), .BUSY(busy8), .DONE(done8)
  );

  uart_tx_framer #(.DATA_WIDTH(5)) dut5 (
    .CLK(clk), .RST(rst_n), .TICK(tick), .P_DATA(p_data5), .DATA_VALID(dv5),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
    .TX_OUT(tx5), .BUSY(busy5), .DONE(done5)
  );

  typedef struct {
    bit         w5;
    logic [8:0] data;
    logic       pe;
    logic       pt;
    logic       s2;
    logic       exp_par;  // hand-derived parity bit
    int         nbits;    // hand-derived frame length in bit periods
  } vec_t;

  vec_t vecs[8];
  bit   sel5;
  int   errors = 0;
  int   checks = 0;
  logic exp_q[$];
  logic cur_bit;

  function automatic logic cur_tx();   return sel5 ? tx5   : tx8;   endfunction
  function automatic logic cur_busy(); return sel5 ? busy5 : busy8; endfunction
  function automatic logic cur_done(); return sel5 ? done5 : done8; endfunction

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic logic pop_exp(input string name);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: frame ran longer than expected bit list", name);
      return 1'b1;
    end
    return exp_q.pop_front();
  endfunction

  // Expected line levels for one frame, start bit first.
  task automatic build_frame(input bit w5, input logic [8:0] data, input logic pe,
                             input logic ep, input logic s2);
    exp_q.push_back(1'b0);
    for (int i = 0; i < (w5 ? 5 : 8); i++) exp_q.push_back(data[i]);
    if (pe) exp_q.push_back(ep);
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
  endtask

  task automatic drive_cfg(input bit w5, input logic [8:0] data, input logic pe,
                           input logic pt, input logic s2);
    sel5 = w5;
    if (w5) p_data5 = data[4:0];
    else    p_data8 = data[7:0];
    par_en  = pe;
    par_typ = pt;
    stop2   = s2;
  endtask

  task automatic set_dv(input logic v);
    dv8 = sel5 ? 1'b0 : v;
    dv5 = sel5 ? v : 1'b0;
  endtask

  task automatic accept(input string tag, input bit tick_too);
    set_dv(1'b1);
    tick = tick_too;
    @(negedge clk);
    set_dv(1'b0);
    tick = 1'b0;
    cur_bit = pop_exp({tag, "_start"});
    check({tag, "_start_tx"}, cur_tx(), cur_bit);
    check({tag, "_start_busy"}, cur_busy(), 1'b1);
  endtask

  // Each bit period: three quiet cycles then one tick. disturb_at >= 0 pokes
  // the inputs and pulses the request during that period.
  task automatic play_bits(input string tag, input int nticks, input int disturb_at);
    for (int t = 0; t < nticks; t++) begin
      @(negedge clk);
      if (t == disturb_at) begin
        p_data8 = ~p_data8;
        p_data5 = ~p_data5;
        par_typ = ~par_typ;
        par_en  = ~par_en;
        stop2   = ~stop2;
        set_dv(1'b1);
      end
      @(negedge clk);
      set_dv(1'b0);
      @(negedge clk);
      check($sformatf("%s_hold%0d_tx", tag, t), cur_tx(), cur_bit);
      check($sformatf("%s_hold%0d_busy", tag, t), cur_busy(), 1'b1);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      cur_bit = pop_exp(tag);
      check($sformatf("%s_bit%0d_tx", tag, t), cur_tx(), cur_bit);
      check($sformatf("%s_bit%0d_nodone", tag, t), cur_done(), 1'b0);
    end
  endtask

  task automatic end_frame(input string tag, input bit next);
    repeat (3) @(negedge clk);
    check({tag, "_laststop_tx"}, cur_tx(), cur_bit);
    tick = 1'b1;
    if (next) set_dv(1'b1);
    @(negedge clk);
    tick = 1'b0;
    set_dv(1'b0);
    check({tag, "_done"}, cur_done(), 1'b1);
    check({tag, "_end_busy"}, cur_busy(), next);
    if (next) begin
      cur_bit = pop_exp({tag, "_b2b"});
      check({tag, "_b2b_start_tx"}, cur_tx(), cur_bit);
    end else begin
      check({tag, "_end_tx"}, cur_tx(), 1'b1);
    end
    @(negedge clk);
    check({tag, "_done_one_cycle"}, cur_done(), 1'b0);
  endtask

  task automatic idle_check(input string tag);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check({tag, "_idle_tx"}, cur_tx(), 1'b1);
    check({tag, "_idle_busy"}, cur_busy(), 1'b0);
    check({tag, "_idle_done"}, cur_done(), 1'b0);
  endtask

  initial begin
    //            w5  data    pe    pt    s2    par   nbits
    vecs[0] = '{1'b0, 9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0, 10};
    vecs[1] = '{1'b0, 9'h007, 1'b1, 1'b0, 1'b0, 1'b1, 11};
    vecs[2] = '{1'b0, 9'h007, 1'b1, 1'b1, 1'b0, 1'b0, 11};
    vecs[3] = '{1'b0, 9'h03C, 1'b1, 1'b0, 1'b1, 1'b0, 12};
    vecs[4] = '{1'b1, 9'h015, 1'b1, 1'b1, 1'b0, 1'b0,  8};
    vecs[5] = '{1'b1, 9'h00B, 1'b0, 1'b0, 1'b1, 1'b0,  8};
    vecs[6] = '{1'b0, 9'h0FF, 1'b1, 1'b1, 1'b0, 1'b1, 11};
    vecs[7] = '{1'b1, 9'h01C, 1'b1, 1'b0, 1'b0, 1'b1,  8};

    rst_n = 1'b0; tick = 1'b0; sel5 = 1'b0;
    p_data8 = '0; p_data5 = '0; dv8 = 1'b0; dv5 = 1'b0;
    par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    cur_bit = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_tx8", tx8, 1'b1);
    check("reset_busy8", busy8, 1'b0);
    check("reset_done8", done8, 1'b0);
    check("reset_tx5", tx5, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: one full frame per entry.
    for (int v = 0; v < 8; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      sel5 = vecs[v].w5;
      idle_check(tag);
      exp_q.delete();
      build_frame(vecs[v].w5, vecs[v].data, vecs[v].pe, vecs[v].exp_par, vecs[v].s2);
      drive_cfg(vecs[v].w5, vecs[v].data, vecs[v].pe, vecs[v].pt, vecs[v].s2);
      accept(tag, 1'b0);
      play_bits(tag, vecs[v].nbits - 1, -1);
      end_frame(tag, 1'b0);
    end

    // Tick on the accept edge must not shorten START.
    exp_q.delete();
    build_frame(1'b0, 9'h0A5, 1'b0, 1'b0, 1'b0);
    drive_cfg(1'b0, 9'h0A5, 1'b0, 1'b0, 1'b0);
    accept("tickacc", 1'b1);
    play_bits("tickacc", 9, -1);
    end_frame("tickacc", 1'b0);

    // Two stop bits, request held at frame end: back-to-back with BUSY high.
    exp_q.delete();
    build_frame(1'b0, 9'h03C, 1'b1, 1'b0, 1'b1);
    drive_cfg(1'b0, 9'h03C, 1'b1, 1'b0, 1'b1);
    accept("b2b_a", 1'b0);
    play_bits("b2b_a", 11, -1);
    build_frame(1'b0, 9'h081, 1'b0, 1'b0, 1'b0);
    drive_cfg(1'b0, 9'h081, 1'b0, 1'b0, 1'b0);
    end_frame("b2b_a", 1'b1);
    play_bits("b2b_b", 9, -1);
    end_frame("b2b_b", 1'b0);

    // Inputs and request disturbed mid-frame: frame unchanged, nothing queued.
    exp_q.delete();
    build_frame(1'b0, 9'h007, 1'b1, 1'b1, 1'b0);
    drive_cfg(1'b0, 9'h007, 1'b1, 1'b0, 1'b0);
    accept("disturb", 1'b0);
    play_bits("disturb", 10, 4);
    end_frame("disturb", 1'b0);
    for (int k = 0; k < 3; k++) idle_check($sformatf("noextra%0d", k));
    drive_cfg(1'b0, 9'h000, 1'b0, 1'b0, 1'b0);

    // Reset while DATA bit 3 (a 0 for 0xA5) is on the line.
    exp_q.delete();
    build_frame(1'b0, 9'h0A5, 1'b0, 1'b0, 1'b0);
    drive_cfg(1'b0, 9'h0A5, 1'b0, 1'b0, 1'b0);
    accept("rst", 1'b0);
    play_bits("rst", 4, -1);
    check("rst_bit3_before", tx8, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_tx", tx8, 1'b1);
    check("rst_async_busy", busy8, 1'b0);
    check("rst_async_done", done8, 1'b0);
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_nodone", done8, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    idle_check("postrst");
    build_frame(1'b0, 9'h03C, 1'b0, 1'b0, 1'b0);
    drive_cfg(1'b0, 9'h03C, 1'b0, 1'b0, 1'b0);
    accept("postrst", 1'b0);
    play_bits("postrst", 9, -1);
    end_frame("postrst", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
